// File: rtl/bicubic_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : bicubic_accum_if
// Purpose  : Product-in / pixel-out handshake bundle for bicubic_accum.
// Revision : 1.0 - initial release
// ============================================================================
interface bicubic_accum_if #(
  parameter int PW = 38
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          in_neg;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_pix;
  logic          out_sat;

  modport master (
    output in_valid, in_prod, in_neg, out_ready,
    input  in_ready, out_valid, out_pix, out_sat
  );

  modport slave (
    input  in_valid, in_prod, in_neg, out_ready,
    output in_ready, out_valid, out_pix, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/bicubic_accum.sv
`default_nettype none
// ============================================================================
// Module   : bicubic_accum
// Purpose  : Signed 16-tap kernel accumulator with shift normalisation and
//            8-bit clamp. Optional macro BICUBIC_ROUND_EN adds half-LSB rounding.
// Revision : 1.0 - initial release
// ============================================================================
module bicubic_accum #(
  parameter int PW    = 38,
  parameter int TAPS  = 16,
  parameter int SHIFT = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  bicubic_accum_if.slave    io_bus
);

  localparam int c_CW = $clog2(TAPS);
  localparam int c_AW = PW + c_CW + 1;

  // One guard bit above the accumulator so the rounding offset cannot wrap.
`ifdef BICUBIC_ROUND_EN
  localparam logic signed [c_AW:0] c_RND = (c_AW+1)'(64'd1 << (SHIFT-1));
`else
  localparam logic signed [c_AW:0] c_RND = '0;
`endif
  localparam logic signed [c_AW:0] c_MAX = (c_AW+1)'(255);

  logic [c_CW-1:0]        r_cnt;
  logic signed [c_AW-1:0] r_acc;
  logic                   r_out_valid;
  logic [7:0]             r_out_pix;
  logic                   r_out_sat;

  logic                   w_last;
  logic                   w_in_ready;
  logic                   w_fire;
  logic signed [c_AW-1:0] w_prod_ext;
  logic signed [c_AW-1:0] w_term;
  logic signed [c_AW-1:0] w_base;
  logic signed [c_AW-1:0] w_sum;
  logic signed [c_AW:0]   w_sum_ext;
  logic signed [c_AW:0]   w_sum_r;
  logic signed [c_AW:0]   w_q;
  logic [7:0]             w_pix;
  logic                   w_sat;

  assign w_last     = (r_cnt == c_CW'(TAPS-1));
  assign w_in_ready = !(w_last && r_out_valid && !io_bus.out_ready);
  assign w_fire     = io_bus.in_valid && w_in_ready;

  assign w_prod_ext = $signed({{(c_CW+1){1'b0}}, io_bus.in_prod});
  assign w_term     = io_bus.in_neg ? -w_prod_ext : w_prod_ext;
  // Tap 0 loads rather than adds, so kernels run back to back without a clear.
  assign w_base     = (r_cnt == '0) ? '0 : r_acc;
  assign w_sum      = w_base + w_term;

  assign w_sum_ext  = {w_sum[c_AW-1], w_sum};
  assign w_sum_r    = w_sum_ext + c_RND;
  assign w_q        = w_sum_r >>> SHIFT;

  always_comb begin
    w_pix = w_q[7:0];
    w_sat = 1'b0;
    if (w_q[c_AW]) begin
      w_pix = 8'd0;
      w_sat = 1'b1;
    end else if (w_q > c_MAX) begin
      w_pix = 8'd255;
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_pix   <= 8'd0;
      r_out_sat   <= 1'b0;
    end else begin
      if (r_out_valid && io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_fire) begin
        r_cnt <= r_cnt + c_CW'(1);
        r_acc <= w_sum;
        if (w_last) begin
          r_out_valid <= 1'b1;
          r_out_pix   <= w_pix;
          r_out_sat   <= w_sat;
        end
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_pix   = r_out_pix;
  assign io_bus.out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_bicubic_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_bicubic_accum
// Purpose  : Self-checking bench for bicubic_accum (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bicubic_accum;

  localparam int PW = 38;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bicubic_accum_if #(.PW(PW)) bus ();

  bicubic_accum #(.PW(PW), .TAPS(16), .SHIFT(20)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       sat;
  } exp_t;

  typedef struct {
    longint     p0;
    logic       n0;
    longint     pr;
    logic       nr;
    logic [7:0] pix;
    logic       sat;
  } vec_t;

  exp_t sb[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard pop plus hold-stability check on the output slot.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_pix  = 8'd0;
  logic       prev_sat  = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_pix", bus.out_pix, prev_pix);
        chk("hold_sat", bus.out_sat, prev_sat);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_pix  = bus.out_pix;
      prev_sat  = bus.out_sat;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pixel: got pix=%0d expected none", bus.out_pix);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_pix", bus.out_pix, e.pix);
          chk("sb_sat", bus.out_sat, e.sat);
        end
      end
    end
  end

  task automatic beat(input longint p, input logic n);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p[PW-1:0];
    bus.in_neg   = n;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got in_ready=0 for %0d cycles expected 1", t);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic kernel(input longint p0, input logic n0, input longint pr, input logic nr);
    beat(p0, n0);
    for (int i = 1; i < 16; i++) beat(pr, nr);
  endtask

  vec_t vecs[11];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint one, pmax;
    one  = 64'd1 << 20;
    pmax = (64'd1 << 38) - 1;

    vecs[0]  = '{one,        1'b0, one,     1'b0, 8'd16,  1'b0};
    vecs[1]  = '{one,        1'b1, one,     1'b1, 8'd0,   1'b1};
    vecs[2]  = '{300*one,    1'b0, 0,       1'b0, 8'd255, 1'b1};
`ifdef BICUBIC_ROUND_EN
    vecs[3]  = '{3*(one/2),  1'b0, 0,       1'b0, 8'd2,   1'b0};
    vecs[6]  = '{one-1,      1'b0, 0,       1'b0, 8'd1,   1'b0};
    vecs[10] = '{1,          1'b1, 0,       1'b0, 8'd0,   1'b0};
`else
    vecs[3]  = '{3*(one/2),  1'b0, 0,       1'b0, 8'd1,   1'b0};
    vecs[6]  = '{one-1,      1'b0, 0,       1'b0, 8'd0,   1'b0};
    vecs[10] = '{1,          1'b1, 0,       1'b0, 8'd0,   1'b1};
`endif
    vecs[4]  = '{255*one,    1'b0, 0,       1'b0, 8'd255, 1'b0};
    vecs[5]  = '{256*one,    1'b0, 0,       1'b0, 8'd255, 1'b1};
    vecs[7]  = '{100*one,    1'b0, 5*one,   1'b1, 8'd25,  1'b0};
    vecs[8]  = '{pmax,       1'b0, pmax,    1'b0, 8'd255, 1'b1};
    vecs[9]  = '{pmax,       1'b1, pmax,    1'b1, 8'd0,   1'b1};

    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_neg    = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_pix",   bus.out_pix,   0);
    chk("rst_sat",   bus.out_sat,   0);
    chk("rst_ready", bus.in_ready,  1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      sb.push_back('{vecs[k].pix, vecs[k].sat});
      kernel(vecs[k].p0, vecs[k].n0, vecs[k].pr, vecs[k].nr);
      chk("latency_valid", bus.out_valid, 1);
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: pixel A parked while kernel B streams up to its last tap.
    bus.out_ready = 1'b0;
    sb.push_back('{8'd16, 1'b0});
    kernel(one, 1'b0, one, 1'b0);
    sb.push_back('{8'd48, 1'b0});
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("bp_ready_early", bus.in_ready, 1);
      beat(3*one, 1'b0);
      chk("bp_a_valid", bus.out_valid, 1);
      chk("bp_a_pix",   bus.out_pix,   16);
    end
    bus.in_valid = 1'b1;
    bus.in_prod  = PW'(3*one);
    bus.in_neg   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_stall", bus.in_ready, 0);
      chk("bp_a_pix_hold",  bus.out_pix,  16);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_release", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_b_valid", bus.out_valid, 1);
    chk("bp_b_pix",   bus.out_pix,   48);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-kernel discards the partial sum.
    for (int i = 0; i < 7; i++) beat(one, 1'b0);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_pix",   bus.out_pix,   0);
      chk("mid_rst_sat",   bus.out_sat,   0);
      chk("mid_rst_ready", bus.in_ready,  1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back('{8'd32, 1'b0});
    kernel(2*one, 1'b0, 2*one, 1'b0);
    chk("mid_rst_out_valid", bus.out_valid, 1);
    chk("mid_rst_out_pix",   bus.out_pix,   32);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bicubic_accum.md
# bicubic_accum

Downstream stage of the three-operand weight multiplier in the bicubic interpolation datapath. It takes the stream of unsigned 38-bit pixel×weight products plus a separate sign flag per product. It accumulates one 4×4 kernel (16 taps) into a signed sum, normalises it by a fixed-point shift, and clamps it to an 8-bit output pixel. Valid/ready handshakes on both sides let it absorb backpressure from the pixel writer.

## Interface
- PW, 38: product width (matches multiplier output).
- TAPS, 16: products per output pixel; must be a power of two, at least 2.
- SHIFT, 20: fraction bits removed from the sum during normalisation; must be at least 1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  product beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_prod  in  PW  unsigned product magnitude.
- in_neg  in  1  1 = product is negative (combined weight sign).
- out_valid  out  1  output pixel present.
- out_ready  in  1  consumer accepts pixel.
- out_pix  out  8  clamped interpolated pixel.
- out_sat  out  1  1 = pixel was clamped (sum <0 or >255 after normalisation).

## Operation
- Accumulator acc is signed, AW = PW + log2(TAPS) + 1 bits (43 at defaults). Tap counter cnt is log2(TAPS) bits.
- A beat is accepted when in_valid && in_ready.
- On each accepted beat:
  - acc += in_prod zero-extended, or acc -= in_prod when in_neg = 1.
  - cnt increments.
- On the first beat of a kernel (cnt == 0), acc is loaded with ±in_prod instead of added to, so no separate clear cycle is needed.
- On the last beat (cnt == TAPS-1), the final sum s = acc ± in_prod is normalised in the same cycle:
  - s_r = s + 2^(SHIFT-1) when rounding is enabled, otherwise s_r = s.
  - q = s_r arithmetic-shifted right by SHIFT.
  - q < 0: out_pix = 0, out_sat = 1.
  - q > 255: out_pix = 255, out_sat = 1.
  - Otherwise: out_pix = q[7:0], out_sat = 0.
  - The result is registered into the output slot, out_valid is set, and cnt wraps to 0.
- Output slot:
  - out_valid && out_ready clears out_valid.
  - out_pix and out_sat hold their value while out_valid = 1 && out_ready = 0.
- in_ready = !(cnt == TAPS-1 && out_valid && !out_ready). Non-final beats are never stalled.
- Simultaneous final beat and output consumption is allowed: the old pixel leaves and the new pixel loads in the same cycle, with out_valid staying 1.
- States (implicit in cnt/out_valid):
  - ACC: cnt 0..TAPS-1.
  - HOLD: final beat blocked because the slot is full. Leaves HOLD when out_ready is asserted.
- Reset:
  - Outputs: out_valid = 0, out_pix = 0, out_sat = 0.
  - Internal: acc = 0, cnt = 0.
  - in_ready is 1 during and after reset.
  - Reset asserted mid-kernel discards the partial sum. The next accepted beat is tap 0.

## Timing
- Beat throughput: 1 per cycle, with no bubbles between kernels.
- Latency: out_valid rises the cycle after the final beat is accepted.
- in_ready is combinational from cnt, out_valid and out_ready. There is no combinational path from in_valid or in_prod to any output.
- Sustained rate: 1 pixel per TAPS cycles when out_ready = 1.

## Configuration
- BICUBIC_ROUND_EN defined: adds 2^(SHIFT-1) before the shift, giving round-half-up toward +inf.
- BICUBIC_ROUND_EN undefined: pure arithmetic shift, giving floor. There is no other difference in behaviour or timing.

## Test plan
- 16 beats of in_prod = 2^20, in_neg = 0, out_ready = 1 → one cycle later: out_valid = 1, out_pix = 16, out_sat = 0.
- 16 beats of in_prod = 2^20, in_neg = 1 → out_pix = 0, out_sat = 1.
- Beat 0: in_prod = 300·2^20; beats 1..15: 0 → out_pix = 255, out_sat = 1.
- Rounding case:
  - Stimulus: beat 0 in_prod = 3·2^19, other beats 0.
  - With BICUBIC_ROUND_EN: out_pix = 2.
  - Without BICUBIC_ROUND_EN: out_pix = 1.
- Backpressure:
  - Stimulus: hold out_ready = 0 after kernel A completes, then stream kernel B continuously.
  - Required: in_ready drops only at B's beat 15, and kernel A's pixel stays stable.
  - Then raise out_ready: A is consumed, B's beat 15 is accepted in the same cycle, and out_pix = B's value on the next cycle.
- Reset mid-kernel:
  - Stimulus: 7 beats of 2^20, assert rst_n = 0 for 2 cycles, release, then send 16 beats of 2·2^20.
  - Required: outputs are 0 during reset, then a single output with out_pix = 32.
